// File: rtl/wys_pkg.sv
// Shared types and default tuning constants for the Watch Your Step game core.
package wys_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_HIT,
      S_FROZEN,
      S_GRACE,
      S_OVER
   } hit_state_t;

   localparam int HIT_FRAMES_DEF   = 2;
   localparam int GRACE_FRAMES_DEF = 120;
   localparam int FLASH_HALF_DEF   = 8;

endpackage

// File: rtl/frame_timer.sv
// Frame-tick down-counter for the grace window plus the flash phase divider.
module frame_timer
   import wys_pkg::*;
#(
   parameter int FLASH_HALF = FLASH_HALF_DEF
) (
   input  logic       clkin,
   input  logic       reset_i,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       tick,
   input  logic       phase_clr,
   input  logic       phase_tick,
   output logic       done,
   output logic       phase_wrap
);

   logic [7:0] count;
   logic [3:0] phase;

   // done fires on the tick that takes the count to zero, so the caller can act on that edge
   assign done       = tick && (count <= 8'd1);
   assign phase_wrap = phase_tick && (phase == 4'(FLASH_HALF - 1));

   always_ff @(posedge clkin or negedge reset_i) begin
      if (!reset_i)
         count <= 8'd0;
      else if (load)
         count <= load_val;
      else if (tick && count != 8'd0)
         count <= count - 8'd1;
   end

   always_ff @(posedge clkin or negedge reset_i) begin
      if (!reset_i)
         phase <= 4'd0;
      else if (phase_clr || phase_wrap)
         phase <= 4'd0;
      else if (phase_tick)
         phase <= phase + 4'd1;
   end

endmodule

// File: rtl/hit_monitor.sv
// Round controller: qualifies hazard hits, pulses the lives decrement, freezes play
// until restart/game over, then runs a grace window with a flashing player.
module hit_monitor
   import wys_pkg::*;
#(
   parameter int HIT_FRAMES   = HIT_FRAMES_DEF,
   parameter int GRACE_FRAMES = GRACE_FRAMES_DEF,
   parameter int FLASH_HALF   = FLASH_HALF_DEF
) (
   input  logic clkin,
   input  logic reset_i,
   input  logic refresh,
   input  logic game_started,
   input  logic hazard_hit,
   input  logic restart,
   input  logic game_over,
   output logic stop_game,
   output logic stop,
   output logic grace,
   output logic flash,
   output logic over
);

   hit_state_t state, state_nxt;
   logic [2:0] hit_cnt, hit_cnt_nxt;
   logic       gs_q;
   logic       flash_nxt;
   logic       tmr_load, tmr_tick, tmr_done;
   logic       ph_clr, ph_tick, ph_wrap;
   logic       in_flash, nxt_flash;

   frame_timer #(.FLASH_HALF(FLASH_HALF)) u_timer (
      .clkin      (clkin),
      .reset_i    (reset_i),
      .load       (tmr_load),
      .load_val   (8'(GRACE_FRAMES)),
      .tick       (tmr_tick),
      .phase_clr  (ph_clr),
      .phase_tick (ph_tick),
      .done       (tmr_done),
      .phase_wrap (ph_wrap)
   );

   always_ff @(posedge clkin or negedge reset_i) begin
      if (!reset_i) begin
         state   <= S_IDLE;
         hit_cnt <= 3'd0;
         gs_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         hit_cnt <= hit_cnt_nxt;
         gs_q    <= game_started;
      end
   end

   always_comb begin
      state_nxt   = state;
      hit_cnt_nxt = 3'd0;
      unique case (state)
         S_IDLE:
            if (game_started && !gs_q) state_nxt = S_RUN;
         S_RUN:
            if (!game_started) state_nxt = S_IDLE;
            else begin
               hit_cnt_nxt = hit_cnt;
               if (refresh) begin
                  hit_cnt_nxt = !hazard_hit ? 3'd0 :
                                (hit_cnt == 3'd7) ? hit_cnt : hit_cnt + 3'd1;
                  if (hit_cnt_nxt >= 3'(HIT_FRAMES)) state_nxt = S_HIT;
               end
            end
         // HIT always completes its pulse, even if the game is abandoned
         S_HIT:
            state_nxt = S_FROZEN;
         S_FROZEN:
            if (!game_started) state_nxt = S_IDLE;
            else if (game_over) state_nxt = S_OVER;
            else if (restart)   state_nxt = S_GRACE;
         S_GRACE:
            if (!game_started) state_nxt = S_IDLE;
            else if (tmr_done) state_nxt = S_RUN;
         S_OVER:
            if (!game_started) state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
      if (state_nxt != S_RUN) hit_cnt_nxt = 3'd0;
   end

   assign in_flash  = (state == S_FROZEN) || (state == S_GRACE);
   assign nxt_flash = (state_nxt == S_FROZEN) || (state_nxt == S_GRACE);
   assign tmr_load  = (state == S_FROZEN) && (state_nxt == S_GRACE);
   assign tmr_tick  = refresh && (state == S_GRACE);
   assign ph_tick   = refresh && in_flash;
   assign ph_clr    = !nxt_flash;

   always_comb begin
      flash_nxt = 1'b0;
      if (state == S_HIT)
         flash_nxt = 1'b1;
      else if (in_flash && nxt_flash)
         flash_nxt = flash ^ ph_wrap;
   end

   always_ff @(posedge clkin or negedge reset_i) begin
      if (!reset_i) begin
         stop_game <= 1'b0;
         stop      <= 1'b0;
         grace     <= 1'b0;
         flash     <= 1'b0;
         over      <= 1'b0;
      end else begin
         stop_game <= (state_nxt == S_HIT);
         stop      <= (state_nxt == S_HIT) || (state_nxt == S_FROZEN) || (state_nxt == S_OVER);
         grace     <= (state_nxt == S_GRACE);
         flash     <= flash_nxt;
         over      <= (state_nxt == S_OVER);
      end
   end

endmodule

// File: tb/tb_hit_monitor.sv
// Directed bench for hit_monitor with a small lives-block model driving restart/game_over.
module tb_hit_monitor;
   import wys_pkg::*;

   logic clkin;
   logic reset_i;
   logic refresh, game_started, hazard_hit, restart, game_over;
   logic stop_game, stop, grace, flash, over;

   logic       btnc, restart_force, lives_load;
   logic [1:0] lives, lives_init;
   int         pulses;
   int         n_chk, n_err;

   hit_monitor dut (
      .clkin        (clkin),
      .reset_i      (reset_i),
      .refresh      (refresh),
      .game_started (game_started),
      .hazard_hit   (hazard_hit),
      .restart      (restart),
      .game_over    (game_over),
      .stop_game    (stop_game),
      .stop         (stop),
      .grace        (grace),
      .flash        (flash),
      .over         (over)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   // lives block: decrements on the edge that ends the stop_game pulse
   always @(posedge clkin) begin
      if (lives_load)
         lives <= lives_init;
      else if (stop_game && lives != 2'd0)
         lives <= lives - 2'd1;
   end
   assign game_over = (lives == 2'd0);
   assign restart   = (btnc && stop && !game_over) || restart_force;

   initial pulses = 0;
   always @(posedge clkin) if (stop_game === 1'b1) pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clkin);
   endtask

   task automatic tick();
      refresh = 1'b1;
      @(negedge clkin);
      refresh = 1'b0;
   endtask

   task automatic load_lives(input logic [1:0] v);
      lives_init = v;
      lives_load = 1'b1;
      cyc(1);
      lives_load = 1'b0;
   endtask

   // hazard over two ticks; returns on the negedge right after the qualifying edge
   task automatic hit2();
      hazard_hit = 1'b1;
      tick();
      cyc(3);
      tick();
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      reset_i = 1'b0; refresh = 1'b0; game_started = 1'b0; hazard_hit = 1'b0;
      btnc = 1'b0; restart_force = 1'b0; lives_init = 2'd3; lives_load = 1'b1;
      cyc(3);
      check("rst_outs", 32'({stop_game, stop, grace, flash, over}), 0);
      reset_i = 1'b1; lives_load = 1'b0;
      cyc(1);

      // hit qualification
      game_started = 1'b1;
      cyc(2);
      hazard_hit = 1'b1; tick(); cyc(3);
      hazard_hit = 1'b0; tick(); cyc(3);
      check("single_tick_no_pulse", 32'(pulses), 0);
      check("single_tick_no_stop", 32'(stop), 0);
      hit2();
      check("pulse_rise", 32'(stop_game), 1);
      check("stop_rise", 32'(stop), 1);
      cyc(1);
      hazard_hit = 1'b0;
      check("pulse_fall", 32'(stop_game), 0);
      check("stop_hold", 32'(stop), 1);
      check("flash_start", 32'(flash), 1);
      check("lives_dec", 32'(lives), 2);

      // flash while frozen: 1 for 8 ticks, 0 for 8 ticks
      for (int k = 1; k <= 16; k++) begin
         tick();
         check($sformatf("flash_frz_%0d", k), 32'(flash), ((k / 8) % 2 == 0) ? 1 : 0);
         cyc(2);
      end
      check("frz_one_pulse", 32'(pulses), 1);

      // restart into grace, button held
      btnc = 1'b1;
      cyc(1);
      check("grace_stop", 32'(stop), 0);
      check("grace_on", 32'(grace), 1);
      cyc(49);
      btnc = 1'b0;
      hazard_hit = 1'b1;
      for (int k = 1; k <= 119; k++) begin
         tick();
         cyc(2);
         if (k == 8) check("flash_grace_8", 32'(flash), 0);
      end
      check("grace_no_pulse", 32'(pulses), 1);
      check("grace_hold", 32'(grace), 1);
      tick();
      check("grace_end", 32'(grace), 0);
      check("run_flash", 32'(flash), 0);
      check("run_stop", 32'(stop), 0);
      cyc(2);
      tick(); cyc(2);
      check("rerun_one_tick", 32'(pulses), 1);
      tick();
      check("repulse", 32'(stop_game), 1);
      cyc(1);
      hazard_hit = 1'b0;
      check("frz2_stop", 32'(stop), 1);

      // async reset mid-FROZEN
      #2 reset_i = 1'b0; game_started = 1'b0;
      #1 check("rst_async_stop", 32'(stop), 0);
      @(negedge clkin) reset_i = 1'b1;
      cyc(2);
      check("rst_idle_state", 32'(dut.state), 32'(S_IDLE));
      check("rst_idle_outs", 32'({stop_game, stop, grace, flash, over}), 0);
      check("rst_no_pulse", 32'(pulses), 2);

      // game over, later restart ignored
      load_lives(2'd1);
      game_started = 1'b1;
      cyc(2);
      hit2();
      hazard_hit = 1'b0;
      check("go_pulse", 32'(stop_game), 1);
      cyc(2);
      check("go_over", 32'(over), 1);
      check("go_stop", 32'(stop), 1);
      check("go_flash", 32'(flash), 0);
      restart_force = 1'b1;
      cyc(3);
      check("go_restart_ignored", 32'(over), 1);
      check("go_no_grace", 32'(grace), 0);
      restart_force = 1'b0;
      game_started = 1'b0;
      cyc(1);
      check("go_exit", 32'({stop, over}), 0);

      // restart and game_over together in first FROZEN cycle
      load_lives(2'd1);
      game_started = 1'b1;
      cyc(2);
      hit2();
      hazard_hit = 1'b0;
      check("sim_pulse", 32'(stop_game), 1);
      restart_force = 1'b1;
      cyc(2);
      check("sim_over", 32'(over), 1);
      check("sim_no_grace", 32'(grace), 0);
      restart_force = 1'b0;
      game_started = 1'b0;
      cyc(2);

      // refresh during HIT is ignored; game_started drop clears flash
      load_lives(2'd3);
      game_started = 1'b1;
      cyc(2);
      hazard_hit = 1'b1;
      tick(); cyc(3);
      refresh = 1'b1;
      @(negedge clkin);
      check("hitref_pulse", 32'(stop_game), 1);
      @(negedge clkin);
      refresh = 1'b0; hazard_hit = 1'b0;
      check("hitref_width", 32'(stop_game), 0);
      for (int k = 1; k <= 7; k++) begin
         tick();
         cyc(2);
      end
      check("hitref_flash7", 32'(flash), 1);
      check("hitref_single", 32'(pulses), 5);
      game_started = 1'b0;
      cyc(1);
      check("drop_flash", 32'(flash), 0);
      check("drop_stop", 32'(stop), 0);
      check("drop_idle", 32'(dut.state), 32'(S_IDLE));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
